fpu_issue_ctrl: RTL

Command sequencer between the CPU decode stage and `fpu`. It accepts one FPU command at a time over a valid/ready handshake and drives the `fpu` operand/opcode/ready interface. It expands the macro operations FDIV and FSQRT into micro-op sequences that use a scratch FPU register. It returns the result with a completion pulse and enforces a watchdog timeout on every micro-op.

---
 rtl/fpu_issue_ctrl_pkg.sv | 37 +++
 rtl/fpu_uprog_rom.sv | 54 +++++
 rtl/fpu_issue_ctrl.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/fpu_issue_ctrl_pkg.sv
// Shared opcodes and micro-op field encoding for the FPU issue controller.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package fpu_issue_ctrl_pkg;

  localparam int FPU_REG_ADDR_WIDTH = 5;
  localparam int FPU_OP_WIDTH       = 5;
  localparam int FPU_REG_COUNT      = 32;

  // Native fpu opcodes
  localparam logic [FPU_OP_WIDTH-1:0] FPU_OPFADD          = 5'd0;
  localparam logic [FPU_OP_WIDTH-1:0] FPU_OPFSUB          = 5'd1;
  localparam logic [FPU_OP_WIDTH-1:0] FPU_OPFMUL          = 5'd2;
  localparam logic [FPU_OP_WIDTH-1:0] FPU_OPFINV_INIT     = 5'd3;
  localparam logic [FPU_OP_WIDTH-1:0] FPU_OPFINV          = 5'd4;
  localparam logic [FPU_OP_WIDTH-1:0] FPU_OPSQRT_INV_INIT = 5'd5;
  localparam logic [FPU_OP_WIDTH-1:0] FPU_OPFCLT          = 5'd6;

  // Macro opcodes, placed in codes the fpu never decodes
  localparam logic [FPU_OP_WIDTH-1:0] FPU_OPFDIV          = 5'd30;
  localparam logic [FPU_OP_WIDTH-1:0] FPU_OPFSQRT         = 5'd31;

  // Register field source for a micro-op
  typedef enum logic [1:0] {
    SEL_X1 = 2'd0,
    SEL_X2 = 2'd1,
    SEL_Y  = 2'd2,
    SEL_S  = 2'd3
  } fld_sel_e;

  typedef struct packed {
    fld_sel_e sel_y;
    fld_sel_e sel_x1;
    fld_sel_e sel_x2;
  } uop_sel_t;

endpackage

// File: rtl/fpu_uprog_rom.sv
// Micro-program ROM: maps (opcode, step index) to the micro-op fields and a last flag.
// Latency: combinational.
// Backpressure: none; the caller chooses when to step the index.
module fpu_uprog_rom
  import fpu_issue_ctrl_pkg::*;
#(
  parameter int OP_W         = FPU_OP_WIDTH,
  parameter int NEWTON_ITERS = 2
) (
  input  logic [OP_W-1:0] i_op,
  input  logic [3:0]      i_idx,
  output logic [OP_W-1:0] o_op,
  output uop_sel_t        o_sel,
  output logic            o_last
);

  localparam logic [3:0] W_LAST_FINV = 4'(NEWTON_ITERS);

  // Decode one micro-op; anything that is not a macro passes straight through
  always_comb begin
    o_op         = i_op;
    o_sel.sel_y  = SEL_Y;
    o_sel.sel_x1 = SEL_X1;
    o_sel.sel_x2 = SEL_X2;
    o_last       = 1'b1;
    if (i_op == OP_W'(FPU_OPFDIV)) begin
      if (i_idx == 4'd0) begin
        o_op         = OP_W'(FPU_OPFINV_INIT);
        o_sel.sel_y  = SEL_S;
        o_sel.sel_x1 = SEL_X2;
        o_last       = 1'b0;
      end else if (i_idx <= W_LAST_FINV) begin
        o_op         = OP_W'(FPU_OPFINV);
        o_sel.sel_y  = SEL_S;
        o_sel.sel_x1 = SEL_X2;
        o_sel.sel_x2 = SEL_S;
        o_last       = 1'b0;
      end else begin
        o_op         = OP_W'(FPU_OPFMUL);
        o_sel.sel_x2 = SEL_S;
      end
    end else if (i_op == OP_W'(FPU_OPFSQRT)) begin
      if (i_idx == 4'd0) begin
        o_op         = OP_W'(FPU_OPSQRT_INV_INIT);
        o_sel.sel_y  = SEL_S;
        o_last       = 1'b0;
      end else begin
        o_op         = OP_W'(FPU_OPFMUL);
        o_sel.sel_x2 = SEL_S;
      end
    end
  end

endmodule

// File: rtl/fpu_issue_ctrl.sv
// Command sequencer in front of the fpu; expands FDIV/FSQRT into micro-op chains with a watchdog.
// Latency: accept->fpu_ready 1 cycle; fpu_valid->rsp_valid 1 cycle; one low GAP cycle between micro-ops.
// Backpressure: cmd_ready only in IDLE; one command in flight, the fpu paces the sequence via fpu_valid.
module fpu_issue_ctrl
  import fpu_issue_ctrl_pkg::*;
#(
  parameter int REG_AW       = FPU_REG_ADDR_WIDTH,
  parameter int OP_W         = FPU_OP_WIDTH,
  parameter int SCRATCH      = FPU_REG_COUNT - 1,
  parameter int NEWTON_ITERS = 2,
  parameter int TIMEOUT      = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [OP_W-1:0]   cmd_op,
  input  logic [REG_AW-1:0] cmd_x1,
  input  logic [REG_AW-1:0] cmd_x2,
  input  logic [REG_AW-1:0] cmd_y,
  input  logic [31:0]       cmd_data,
  output logic              rsp_valid,
  output logic [31:0]       rsp_data,
  output logic              rsp_cond,
  output logic              rsp_err,
  output logic              busy,
  output logic [REG_AW-1:0] fpu_x1,
  output logic [REG_AW-1:0] fpu_x2,
  output logic [REG_AW-1:0] fpu_y,
  output logic [OP_W-1:0]   fpu_op,
  output logic [31:0]       fpu_in_data,
  output logic              fpu_ready,
  input  logic              fpu_valid,
  input  logic [31:0]       fpu_out_data,
  input  logic              fpu_cond
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_GAP   = 2'd2;

  localparam int               WD_W = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0]  W_WD_MAX = WD_W'(TIMEOUT);
  localparam logic [REG_AW-1:0] W_S = REG_AW'(SCRATCH);

  logic [1:0]        r_state;
  logic [OP_W-1:0]   r_op;
  logic [REG_AW-1:0] r_x1, r_x2, r_y;
  logic [3:0]        r_idx;
  logic [WD_W-1:0]   r_wd;
  logic              r_rsp_valid, r_rsp_err;
  logic [31:0]       r_rsp_data;
  logic [OP_W-1:0]   r_fpu_op;
  logic [REG_AW-1:0] r_fpu_x1, r_fpu_x2, r_fpu_y;
  logic [31:0]       r_fpu_in_data;

  logic              w_idle, w_issue, w_accept, w_macro, w_conflict, w_start;
  logic              w_done, w_timeout, w_load, w_last;
  logic [OP_W-1:0]   w_rom_op_in, w_rom_op;
  logic [3:0]        w_rom_idx;
  logic [REG_AW-1:0] w_src_x1, w_src_x2, w_src_y;
  uop_sel_t          w_sel;

  function automatic logic [REG_AW-1:0] sel_addr(input fld_sel_e s, input logic [REG_AW-1:0] a1,
                                                 input logic [REG_AW-1:0] a2, input logic [REG_AW-1:0] ay);
    case (s)
      SEL_X1:  return a1;
      SEL_X2:  return a2;
      SEL_Y:   return ay;
      default: return W_S;
    endcase
  endfunction

  assign w_idle     = (r_state == ST_IDLE);
  assign w_issue    = (r_state == ST_ISSUE);
  assign w_accept   = cmd_valid && w_idle;
  assign w_macro    = (cmd_op == OP_W'(FPU_OPFDIV)) || (cmd_op == OP_W'(FPU_OPFSQRT));
  assign w_conflict = w_macro && ((cmd_x1 == W_S) || (cmd_x2 == W_S) || (cmd_y == W_S));
  assign w_start    = w_accept && !w_conflict;
  assign w_done     = w_issue && fpu_valid;
  assign w_timeout  = w_issue && !fpu_valid && (r_wd == W_WD_MAX);
  assign w_load     = w_start || (r_state == ST_GAP);

  // In IDLE the ROM looks at the incoming command so step 0 can be loaded on accept
  assign w_rom_op_in = w_idle ? cmd_op : r_op;
  assign w_rom_idx   = w_idle ? 4'd0   : r_idx;
  assign w_src_x1    = w_idle ? cmd_x1 : r_x1;
  assign w_src_x2    = w_idle ? cmd_x2 : r_x2;
  assign w_src_y     = w_idle ? cmd_y  : r_y;

  fpu_uprog_rom #(
    .OP_W         (OP_W),
    .NEWTON_ITERS (NEWTON_ITERS)
  ) u_rom (
    .i_op   (w_rom_op_in),
    .i_idx  (w_rom_idx),
    .o_op   (w_rom_op),
    .o_sel  (w_sel),
    .o_last (w_last)
  );

  // Sequencer state, command latch, step index and watchdog
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_op    <= '0;
      r_x1    <= '0;
      r_x2    <= '0;
      r_y     <= '0;
      r_idx   <= '0;
      r_wd    <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_op    <= cmd_op;
            r_x1    <= cmd_x1;
            r_x2    <= cmd_x2;
            r_y     <= cmd_y;
            r_idx   <= 4'd0;
            r_wd    <= '0;
            r_state <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (fpu_valid) begin
            r_wd    <= '0;
            r_idx   <= r_idx + 4'd1;
            r_state <= w_last ? ST_IDLE : ST_GAP;
          end else if (r_wd == W_WD_MAX) begin
            r_wd    <= '0;
            r_state <= ST_IDLE;
          end else begin
            r_wd <= r_wd + 1'b1;
          end
        end
        ST_GAP:  r_state <= ST_ISSUE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // fpu fields are registered so they hold steady for the whole ISSUE state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fpu_op      <= '0;
      r_fpu_x1      <= '0;
      r_fpu_x2      <= '0;
      r_fpu_y       <= '0;
      r_fpu_in_data <= '0;
    end else begin
      if (w_load) begin
        r_fpu_op <= w_rom_op;
        r_fpu_x1 <= sel_addr(w_sel.sel_x1, w_src_x1, w_src_x2, w_src_y);
        r_fpu_x2 <= sel_addr(w_sel.sel_x2, w_src_x1, w_src_x2, w_src_y);
        r_fpu_y  <= sel_addr(w_sel.sel_y,  w_src_x1, w_src_x2, w_src_y);
      end
      if (w_start) r_fpu_in_data <= cmd_data;
    end
  end

  // Completion pulse, error flag and captured result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_data  <= '0;
    end else begin
      r_rsp_valid <= (w_done && w_last) || w_timeout || (w_accept && w_conflict);
      r_rsp_err   <= w_timeout || (w_accept && w_conflict);
      if (w_done) r_rsp_data <= fpu_out_data;
    end
  end

  assign cmd_ready   = w_idle;
  assign busy        = !w_idle;
  assign fpu_ready   = w_issue;
  assign fpu_op      = r_fpu_op;
  assign fpu_x1      = r_fpu_x1;
  assign fpu_x2      = r_fpu_x2;
  assign fpu_y       = r_fpu_y;
  assign fpu_in_data = r_fpu_in_data;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_err     = r_rsp_err;
  assign rsp_data    = r_rsp_data;
  assign rsp_cond    = fpu_cond;

endmodule
